// File: rtl/arb_pkg.sv
// Shared definitions for the memory arbiter.
// Default bus widths, the supported requester range, and a helper that sizes
// a core-index field.
package arb_pkg;

  localparam int unsigned AddrWDefault = 32;
  localparam int unsigned DataWDefault = 8;
  localparam int unsigned MaxCores     = 8;

  // Width of a field holding a core index; at least one bit so a single-core
  // configuration still has a legal vector.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Finds the first requester after the last winner, wrapping modulo N_CORES.
// The last winner itself is searched last, so a lone requester can still win.
// Ports:
//   req    in   per-core request vector
//   last   in   index of the previous winner
//   gnt    out  one-hot winner (zero when no request)
//   idx    out  index of the winner (0 when no request)
//   valid  out  at least one request present
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N_CORES = 2,
  localparam int unsigned IdxW   = idx_w(N_CORES)
) (
  input  logic [N_CORES-1:0] req,
  input  logic [IdxW-1:0]    last,
  output logic [N_CORES-1:0] gnt,
  output logic [IdxW-1:0]    idx,
  output logic               valid
);

  int cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int k = 1; k <= int'(N_CORES); k++) begin
      cand = (int'(last) + k) % int'(N_CORES);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shared byte-wide memory arbiter for the CPU cores.
// One winner per cycle, round-robin fair, with a short locked burst so a core
// can finish a multi-byte instruction fetch without interleaving.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   req        in   per-core request, held until granted
//   we         in   per-core write enable (1 = store)
//   lock       in   per-core burst hint
//   addr       in   per-core address, core i at [i*ADDR_W +: ADDR_W]
//   wdata      in   per-core store data, core i at [i*DATA_W +: DATA_W]
//   grant      out  registered one-hot grant pulse
//   owner      out  index of the current (or most recent) grant holder
//   mem_addr   out  owner's address
//   mem_wdata  out  owner's store data
//   mem_read   out  read strobe, only for a live granted read
//   mem_write  out  write strobe, only for a live granted store
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N_CORES   = 2,
  parameter int unsigned ADDR_W    = AddrWDefault,
  parameter int unsigned DATA_W    = DataWDefault,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned IdxW     = idx_w(N_CORES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CORES-1:0]        req,
  input  logic [N_CORES-1:0]        we,
  input  logic [N_CORES-1:0]        lock,
  input  logic [N_CORES*ADDR_W-1:0] addr,
  input  logic [N_CORES*DATA_W-1:0] wdata,
  output logic [N_CORES-1:0]        grant,
  output logic [IdxW-1:0]           owner,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_read,
  output logic                      mem_write
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  if (N_CORES < 2 || N_CORES > MaxCores) begin : g_bad_cores
    $error("mem_arbiter: N_CORES out of supported range");
  end

  logic [N_CORES-1:0] grant_q, grant_d;
  logic [IdxW-1:0]    owner_q, owner_d;
  logic [IdxW-1:0]    last_q, last_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic [N_CORES-1:0] pick_gnt;
  logic [IdxW-1:0]    pick_idx;
  logic               pick_valid;

  logic [N_CORES-1:0] last_oh;
  logic               others_req;
  logic               hold;

  rr_pick #(
    .N_CORES(N_CORES)
  ) u_rr_pick (
    .req  (req),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .valid(pick_valid)
  );

  always_comb begin
    last_oh         = '0;
    last_oh[last_q] = 1'b1;
    others_req      = |(req & ~last_oh);
    // The burst limit only bites when someone else is waiting; a lone locked
    // requester keeps the bus with the counter parked at MAX_BURST.
    hold = lock[last_q] & req[last_q] & ((cnt_q < CntW'(MAX_BURST)) | ~others_req);

    grant_d = '0;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = '0;
    if (hold) begin
      grant_d = last_oh;
      owner_d = last_q;
      cnt_d   = (cnt_q < CntW'(MAX_BURST)) ? cnt_q + CntW'(1) : cnt_q;
    end else if (pick_valid) begin
      grant_d = pick_gnt;
      owner_d = pick_idx;
      last_d  = pick_idx;
      cnt_d   = CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IdxW'(N_CORES - 1);
      cnt_q   <= '0;
    end else begin
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      if (owner_q == IdxW'(i)) begin
        mem_addr  = addr[i*ADDR_W +: ADDR_W];
        mem_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // A grant whose owner already dropped req is a dead slot: no access.
  always_comb begin
    grant     = grant_q;
    owner     = owner_q;
    mem_read  = |(grant_q & req & ~we);
    mem_write = |(grant_q & req & we);
  end

endmodule
